// File: rtl/bram_mem_responder.sv
// Block-RAM-backed stand-in for the DDR2 controller on the cpu_req/cpu_res interface.
// Define MEM_RESP_RANDLAT_EN to add LFSR-driven latency jitter of 0..7 extra cycles.
`timescale 1ns/1ps

module bram_mem_responder #(
    parameter int AW      = 16,
    parameter int LATENCY = 4
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic [26:0] cpu_req_addr,
    input  logic [31:0] cpu_req_data,
    input  logic        cpu_req_rw,
    input  logic        cpu_req_valid,
    output logic [31:0] cpu_res_data,
    output logic        cpu_res_ready,
    output logic        busy,
    output logic        oor
);

    // Wide enough for LATENCY-1 plus the optional 0..7 jitter.
    localparam int CW = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [CW-1:0]  lat_load;

    logic           accept;
    logic           req_oor;
    logic [AW-1:0]  req_idx;

    logic [AW-1:0]  idx_q;
    logic [31:0]    data_q;
    logic           rw_q;
    logic           oor_q;
    logic [31:0]    hold_q;
    logic           mem_we;

    logic [31:0]    mem [2**AW];

    // Address bit 0 selects a half-word on the DDR side; the word array ignores it.
    logic           addr_bit0_unused;
    assign addr_bit0_unused = cpu_req_addr[0];

    assign req_idx = cpu_req_addr[AW:1];
    assign req_oor = |(cpu_req_addr >> (AW + 1));
    assign accept  = rstn && (state == IDLE) && cpu_req_valid;
    assign mem_we  = rstn && (state == RESP) && rw_q && !oor_q;

`ifdef MEM_RESP_RANDLAT_EN
    logic [15:0] lfsr;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign lat_load = CW'(LATENCY - 1) + CW'(lfsr[2:0]);
`else
    assign lat_load = CW'(LATENCY - 1);
`endif

    // NOTE: every clocked register uses <= so all flops see the pre-edge values of their peers.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cpu_req_valid) begin
                    cnt_nxt   = lat_load;
                    state_nxt = (lat_load == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_res_ready = (state == RESP);
        busy          = (state != IDLE);
        oor           = (state == RESP) && oor_q;
        cpu_res_data  = ((state == RESP) && !rw_q && !oor_q) ? hold_q : 32'h0;
    end

    // Request fields are frozen at accept; later input changes are ignored until RESP.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            idx_q  <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
            oor_q  <= 1'b0;
        end else if (accept) begin
            idx_q  <= req_idx;
            data_q <= cpu_req_data;
            rw_q   <= cpu_req_rw;
            oor_q  <= req_oor;
        end
    end

    // NOTE: the array and its read register have no reset; contents must survive rstn.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[idx_q] <= data_q;
        end
        if (accept) begin
            hold_q <= mem[req_idx];
        end
    end

endmodule
